// File: rtl/chess_move_entry.sv
// -----------------------------------------------------------------------------
// ChessMoveEntry: move-entry front end and dual game clock.
//
// Turns PS/2 key events into board coordinates and game commands, and issues
// them as single-word writes to data memory over a valid/ready port.
// Also runs the white and black countdown clocks with an optional Fischer
// increment, driven by a snooped copy of the processor's status word.
//
// Ports
//   clock       system clock
//   reset_n     asynchronous active-low reset
//   key_valid   one-cycle strobe, key_code carries a new scan code
//   key_code    PS/2 set-2 scan code
//   key_break   code is a key release (ignored)
//   mem_addr    processor data-memory address (snooped)
//   mem_data    processor data-memory data (snooped)
//   wr_valid    write request pending
//   wr_ready    arbiter accepts the request this cycle
//   wr_addr     write address
//   wr_data     write data
//   white_time  white remaining ticks
//   black_time  black remaining ticks
//   game_over   a flag has fallen
//   winner      0 = white, 1 = black (meaningful while game_over = 1)
// -----------------------------------------------------------------------------
module chess_move_entry #(
  parameter int unsigned     TIME_W      = 42,
  parameter longint unsigned START_TICKS = 64'd6049999999,
  parameter longint unsigned INCR_TICKS  = 64'd0,
  parameter int unsigned     ADDR_W      = 12,
  parameter int unsigned     DATA_W      = 32,
  parameter longint unsigned BASE_ADDR   = 64'd64
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              key_valid,
  input  logic [7:0]        key_code,
  input  logic              key_break,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [TIME_W-1:0] white_time,
  output logic [TIME_W-1:0] black_time,
  output logic              game_over,
  output logic              winner
);

  localparam logic [TIME_W-1:0] START_T = TIME_W'(START_TICKS);
  localparam logic [TIME_W-1:0] INCR_T  = TIME_W'(INCR_TICKS);
  localparam logic [TIME_W-1:0] ONE_T   = TIME_W'(1);

  localparam logic [ADDR_W-1:0] ADDR_SLOT0  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_SLOT1  = ADDR_W'(BASE_ADDR + 64'd1);
  localparam logic [ADDR_W-1:0] ADDR_STATUS = ADDR_W'(BASE_ADDR + 64'd2);
  localparam logic [ADDR_W-1:0] ADDR_CMD_R  = ADDR_W'(BASE_ADDR + 64'd3);
  localparam logic [ADDR_W-1:0] ADDR_CMD_K  = ADDR_W'(BASE_ADDR + 64'd4);
  localparam logic [ADDR_W-1:0] ADDR_CMD_L  = ADDR_W'(BASE_ADDR + 64'd6);

  localparam logic [DATA_W-1:0] CMD_DATA = {{(DATA_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PART  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        letter_q, letter_d;
  logic [2:0]        num_q, num_d;
  logic              haveLetter_q, haveLetter_d;
  logic              haveNum_q, haveNum_d;
  logic              slot_q, slot_d;
  logic [ADDR_W-1:0] wrAddr_q, wrAddr_d;
  logic [DATA_W-1:0] wrData_q, wrData_d;
  logic              pendValid_q, pendValid_d;
  logic [ADDR_W-1:0] pendAddr_q, pendAddr_d;
  logic [1:0]        status_q, status_d;
  logic [TIME_W-1:0] white_q, white_d;
  logic [TIME_W-1:0] black_q, black_d;
  logic              gameOver_q, gameOver_d;
  logic              winner_q, winner_d;

  logic              isLetter, isDigit, isLeft, isRight, isCmd;
  logic [2:0]        coord;
  logic [ADDR_W-1:0] cmdAddr;
  logic              keyEvt, cmdNow, moveOk, snoop;
  logic [1:0]        statusEff;
  logic [TIME_W:0]   whiteSum, blackSum;
  logic [ADDR_W-1:0] slotAddr;
  logic              unusedStatusBits;

  // Only the turn and pause bits of the status word matter here.
  assign unusedStatusBits = ^mem_data[DATA_W-1:2];

  // Scan-code decoder: classify the key and give its board coordinate or
  // command address. Release codes are screened out later via keyEvt.
  always_comb begin
    isLetter = 1'b0;
    isDigit  = 1'b0;
    isLeft   = 1'b0;
    isRight  = 1'b0;
    isCmd    = 1'b0;
    coord    = 3'd0;
    cmdAddr  = ADDR_CMD_R;
    case (key_code)
      8'h1C: begin isLetter = 1'b1; coord = 3'd0; end
      8'h32: begin isLetter = 1'b1; coord = 3'd1; end
      8'h21: begin isLetter = 1'b1; coord = 3'd2; end
      8'h23: begin isLetter = 1'b1; coord = 3'd3; end
      8'h24: begin isLetter = 1'b1; coord = 3'd4; end
      8'h2B: begin isLetter = 1'b1; coord = 3'd5; end
      8'h34: begin isLetter = 1'b1; coord = 3'd6; end
      8'h33: begin isLetter = 1'b1; coord = 3'd7; end
      8'h16: begin isDigit = 1'b1; coord = 3'd0; end
      8'h1E: begin isDigit = 1'b1; coord = 3'd1; end
      8'h26: begin isDigit = 1'b1; coord = 3'd2; end
      8'h25: begin isDigit = 1'b1; coord = 3'd3; end
      8'h2E: begin isDigit = 1'b1; coord = 3'd4; end
      8'h36: begin isDigit = 1'b1; coord = 3'd5; end
      8'h3D: begin isDigit = 1'b1; coord = 3'd6; end
      8'h3E: begin isDigit = 1'b1; coord = 3'd7; end
      8'h6B: isLeft  = 1'b1;
      8'h74: isRight = 1'b1;
      8'h2D: begin isCmd = 1'b1; cmdAddr = ADDR_CMD_R; end
      8'h42: begin isCmd = 1'b1; cmdAddr = ADDR_CMD_K; end
      8'h4B: begin isCmd = 1'b1; cmdAddr = ADDR_CMD_L; end
      default: ;
    endcase
  end

  assign keyEvt   = key_valid && !key_break;
  assign cmdNow   = keyEvt && isCmd;
  // Move keys are frozen out once a flag falls or the game is paused.
  assign moveOk   = keyEvt && !gameOver_q && !status_q[1];
  assign snoop    = (mem_addr == ADDR_STATUS);
  assign slotAddr = slot_q ? ADDR_SLOT1 : ADDR_SLOT0;

  // Entry FSM: gathers a letter and a digit in either order, then holds the
  // write until the arbiter takes it. A command seen during a write waits in
  // the pending register and goes out straight after the current handshake;
  // a command landing on the accepting cycle itself is issued directly.
  always_comb begin
    state_d      = state_q;
    letter_d     = letter_q;
    num_d        = num_q;
    haveLetter_d = haveLetter_q;
    haveNum_d    = haveNum_q;
    slot_d       = slot_q;
    wrAddr_d     = wrAddr_q;
    wrData_d     = wrData_q;
    pendValid_d  = pendValid_q;
    pendAddr_d   = pendAddr_q;
    case (state_q)
      IDLE, PART: begin
        if (cmdNow) begin
          letter_d     = 3'd0;
          num_d        = 3'd0;
          haveLetter_d = 1'b0;
          haveNum_d    = 1'b0;
          wrAddr_d     = cmdAddr;
          wrData_d     = CMD_DATA;
          state_d      = WRITE;
        end else if (moveOk) begin
          if (isLeft || isRight) begin
            slot_d       = isRight;
            letter_d     = 3'd0;
            num_d        = 3'd0;
            haveLetter_d = 1'b0;
            haveNum_d    = 1'b0;
            state_d      = IDLE;
          end else if (isLetter) begin
            letter_d     = coord;
            haveLetter_d = 1'b1;
            if (haveNum_q) begin
              wrAddr_d = slotAddr;
              wrData_d = {{(DATA_W-6){1'b0}}, num_q, coord};
              state_d  = WRITE;
            end else begin
              state_d  = PART;
            end
          end else if (isDigit) begin
            num_d     = coord;
            haveNum_d = 1'b1;
            if (haveLetter_q) begin
              wrAddr_d = slotAddr;
              wrData_d = {{(DATA_W-6){1'b0}}, coord, letter_q};
              state_d  = WRITE;
            end else begin
              state_d  = PART;
            end
          end
        end
      end
      WRITE: begin
        if (cmdNow) begin
          pendValid_d  = 1'b1;
          pendAddr_d   = cmdAddr;
          letter_d     = 3'd0;
          num_d        = 3'd0;
          haveLetter_d = 1'b0;
          haveNum_d    = 1'b0;
        end
        if (wr_ready) begin
          letter_d     = 3'd0;
          num_d        = 3'd0;
          haveLetter_d = 1'b0;
          haveNum_d    = 1'b0;
          if (cmdNow) begin
            wrAddr_d    = cmdAddr;
            wrData_d    = CMD_DATA;
            pendValid_d = 1'b0;
          end else if (pendValid_q) begin
            wrAddr_d    = pendAddr_q;
            wrData_d    = CMD_DATA;
            pendValid_d = 1'b0;
          end else begin
            state_d     = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Game clocks. A restart command beats everything; otherwise a snooped
  // status write takes effect this very cycle, so the increment goes to the
  // player who just moved and the decrement to the new player to move.
  always_comb begin
    white_d    = white_q;
    black_d    = black_q;
    gameOver_d = gameOver_q;
    winner_d   = winner_q;
    status_d   = status_q;
    statusEff  = snoop ? mem_data[1:0] : status_q;
    whiteSum   = {1'b0, white_q} + {1'b0, INCR_T};
    blackSum   = {1'b0, black_q} + {1'b0, INCR_T};
    if (cmdNow) begin
      white_d    = START_T;
      black_d    = START_T;
      gameOver_d = 1'b0;
      winner_d   = 1'b0;
      status_d   = 2'b00;
    end else begin
      status_d = statusEff;
      if (!gameOver_q) begin
        if (snoop && (mem_data[0] != status_q[0])) begin
          if (status_q[0]) begin
            black_d = blackSum[TIME_W] ? {TIME_W{1'b1}} : blackSum[TIME_W-1:0];
          end else begin
            white_d = whiteSum[TIME_W] ? {TIME_W{1'b1}} : whiteSum[TIME_W-1:0];
          end
        end
        if (!statusEff[1]) begin
          if (statusEff[0]) begin
            if (black_q != '0) begin
              black_d = black_q - ONE_T;
              if (black_q == ONE_T) begin
                gameOver_d = 1'b1;
                winner_d   = 1'b0;
              end
            end
          end else begin
            if (white_q != '0) begin
              white_d = white_q - ONE_T;
              if (white_q == ONE_T) begin
                gameOver_d = 1'b1;
                winner_d   = 1'b1;
              end
            end
          end
        end
      end
    end
  end

  // State registers; reset drops any in-flight request at once.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      letter_q     <= 3'd0;
      num_q        <= 3'd0;
      haveLetter_q <= 1'b0;
      haveNum_q    <= 1'b0;
      slot_q       <= 1'b0;
      wrAddr_q     <= ADDR_SLOT0;
      wrData_q     <= '0;
      pendValid_q  <= 1'b0;
      pendAddr_q   <= ADDR_CMD_R;
      status_q     <= 2'b00;
      white_q      <= START_T;
      black_q      <= START_T;
      gameOver_q   <= 1'b0;
      winner_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      letter_q     <= letter_d;
      num_q        <= num_d;
      haveLetter_q <= haveLetter_d;
      haveNum_q    <= haveNum_d;
      slot_q       <= slot_d;
      wrAddr_q     <= wrAddr_d;
      wrData_q     <= wrData_d;
      pendValid_q  <= pendValid_d;
      pendAddr_q   <= pendAddr_d;
      status_q     <= status_d;
      white_q      <= white_d;
      black_q      <= black_d;
      gameOver_q   <= gameOver_d;
      winner_q     <= winner_d;
    end
  end

  assign wr_valid   = (state_q == WRITE);
  assign wr_addr    = wrAddr_q;
  assign wr_data    = wrData_q;
  assign white_time = white_q;
  assign black_time = black_q;
  assign game_over  = gameOver_q;
  assign winner     = winner_q;

endmodule

// File: tb/tb_chess_move_entry.sv
// -----------------------------------------------------------------------------
// Testbench for chess_move_entry.
// Instance A (default parameters) exercises key entry and the write port;
// instance B (START_TICKS=10, INCR_TICKS=3) exercises the game clocks.
// Both share key and snoop inputs; A's writes are scored against a queue.
// -----------------------------------------------------------------------------
module tb_chess_move_entry;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
  } wrExp_t;

  typedef struct {
    logic [7:0]  letterKey;
    logic [7:0]  digitKey;
    logic        letterFirst;
    logic        slot;
    logic [11:0] expAddr;
    logic [31:0] expData;
  } moveVec_t;

  localparam logic [63:0] START_A = 64'd6049999999;
  localparam logic [63:0] START_B = 64'd10;

  logic        clock;
  logic        reset_n;
  logic        keyValid;
  logic [7:0]  keyCode;
  logic        keyBreak;
  logic [11:0] memAddr;
  logic [31:0] memData;

  logic        wrValidA, wrReadyA, gameOverA, winnerA;
  logic [11:0] wrAddrA;
  logic [31:0] wrDataA;
  logic [41:0] whiteA, blackA;

  logic        wrValidB, gameOverB, winnerB;
  logic [11:0] wrAddrB;
  logic [31:0] wrDataB;
  logic [41:0] whiteB, blackB;

  int          checks;
  int          failures;
  wrExp_t      expQ[$];
  wrExp_t      monExp;
  moveVec_t    vecs[6];

  chess_move_entry u_dutA (
    .clock      (clock),
    .reset_n    (reset_n),
    .key_valid  (keyValid),
    .key_code   (keyCode),
    .key_break  (keyBreak),
    .mem_addr   (memAddr),
    .mem_data   (memData),
    .wr_valid   (wrValidA),
    .wr_ready   (wrReadyA),
    .wr_addr    (wrAddrA),
    .wr_data    (wrDataA),
    .white_time (whiteA),
    .black_time (blackA),
    .game_over  (gameOverA),
    .winner     (winnerA)
  );

  chess_move_entry #(
    .START_TICKS (64'd10),
    .INCR_TICKS  (64'd3)
  ) u_dutB (
    .clock      (clock),
    .reset_n    (reset_n),
    .key_valid  (keyValid),
    .key_code   (keyCode),
    .key_break  (keyBreak),
    .mem_addr   (memAddr),
    .mem_data   (memData),
    .wr_valid   (wrValidB),
    .wr_ready   (1'b1),
    .wr_addr    (wrAddrB),
    .wr_data    (wrDataB),
    .white_time (whiteB),
    .black_time (blackB),
    .game_over  (gameOverB),
    .winner     (winnerB)
  );

  // Free-running clock, period 10.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Hard stop in case something wedges.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic sendKey(input logic [7:0] code, input logic brk);
    keyValid = 1'b1;
    keyCode  = code;
    keyBreak = brk;
    stepCycle();
    keyValid = 1'b0;
    keyBreak = 1'b0;
  endtask

  task automatic pushExp(input logic [11:0] addr, input logic [31:0] data);
    wrExp_t e;
    e.addr = addr;
    e.data = data;
    expQ.push_back(e);
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while (expQ.size() != 0 && n < budget) begin
      stepCycle();
      n++;
    end
    if (expQ.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain: %0d writes outstanding, expected 0", expQ.size());
      expQ.delete();
    end
  endtask

  task automatic applyStimulus(input moveVec_t v);
    pushExp(v.expAddr, v.expData);
    sendKey(v.slot ? 8'h74 : 8'h6B, 1'b0);
    if (v.letterFirst) begin
      sendKey(v.letterKey, 1'b0);
      sendKey(v.digitKey, 1'b0);
    end else begin
      sendKey(v.digitKey, 1'b0);
      sendKey(v.letterKey, 1'b0);
    end
  endtask

  // Scoreboard: a handshake seen away from the edge pops the next expected write.
  always @(negedge clock) begin
    if (reset_n && wrValidA && wrReadyA) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", wrAddrA, wrDataA);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("wr_addr", 64'(wrAddrA), 64'(monExp.addr));
        checkOutput("wr_data", 64'(wrDataA), 64'(monExp.data));
      end
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    keyValid = 1'b0;
    keyCode  = 8'h00;
    keyBreak = 1'b0;
    memAddr  = 12'd0;
    memData  = 32'd0;
    wrReadyA = 1'b1;

    vecs[0] = '{8'h24, 8'h25, 1'b1, 1'b0, 12'd64, 32'h1C};
    vecs[1] = '{8'h32, 8'h1E, 1'b0, 1'b1, 12'd65, 32'h09};
    vecs[2] = '{8'h33, 8'h3E, 1'b1, 1'b0, 12'd64, 32'h3F};
    vecs[3] = '{8'h1C, 8'h16, 1'b0, 1'b1, 12'd65, 32'h00};
    vecs[4] = '{8'h21, 8'h36, 1'b0, 1'b0, 12'd64, 32'h2A};
    vecs[5] = '{8'h34, 8'h2E, 1'b1, 1'b1, 12'd65, 32'h26};

    // Reset values
    repeat (3) stepCycle();
    checkOutput("rst_wr_valid", 64'(wrValidA), 64'd0);
    checkOutput("rst_wr_addr", 64'(wrAddrA), 64'd64);
    checkOutput("rst_wr_data", 64'(wrDataA), 64'd0);
    checkOutput("rst_game_over", 64'(gameOverA), 64'd0);
    checkOutput("rst_winner", 64'(winnerA), 64'd0);
    checkOutput("rst_white_a", 64'(whiteA), START_A);
    checkOutput("rst_black_a", 64'(blackA), START_A);
    checkOutput("rst_white_b", 64'(whiteB), START_B);
    reset_n = 1'b1;

    // Move vectors with the arbiter always ready
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i]);
      waitDrain(10);
      checkOutput("wr_valid_one_cycle", 64'(wrValidA), 64'd0);
    end

    // Instance B: white ran out unattended, black wins
    checkOutput("b_white_flag", 64'(whiteB), 64'd0);
    checkOutput("b_black_idle", 64'(blackB), START_B);
    checkOutput("b_game_over_white", 64'(gameOverB), 64'd1);
    checkOutput("b_winner_black", 64'(winnerB), 64'd1);

    // Release codes are ignored
    pushExp(12'd64, 32'h1C);
    sendKey(8'h6B, 1'b0);
    sendKey(8'h24, 1'b0);
    sendKey(8'h3E, 1'b1);
    sendKey(8'h25, 1'b0);
    waitDrain(10);

    // Backpressure: request held stable for 5 cycles
    wrReadyA = 1'b0;
    pushExp(12'd65, 32'h09);
    sendKey(8'h74, 1'b0);
    sendKey(8'h1E, 1'b0);
    sendKey(8'h32, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("hold_valid", 64'(wrValidA), 64'd1);
      checkOutput("hold_addr", 64'(wrAddrA), 64'd65);
      checkOutput("hold_data", 64'(wrDataA), 64'h09);
      stepCycle();
    end
    wrReadyA = 1'b1;
    waitDrain(10);
    checkOutput("hold_release", 64'(wrValidA), 64'd0);

    // Command during a move write: move first, then the command
    wrReadyA = 1'b0;
    pushExp(12'd64, 32'h1C);
    sendKey(8'h6B, 1'b0);
    sendKey(8'h24, 1'b0);
    sendKey(8'h25, 1'b0);
    sendKey(8'h42, 1'b0);
    pushExp(12'd68, 32'd1);
    checkOutput("k_white_reload", 64'(whiteA), START_A);
    checkOutput("k_black_reload", 64'(blackA), START_A);
    wrReadyA = 1'b1;
    waitDrain(10);

    // A later pending command replaces an earlier one
    wrReadyA = 1'b0;
    pushExp(12'd65, 32'h12);
    sendKey(8'h74, 1'b0);
    sendKey(8'h21, 1'b0);
    sendKey(8'h26, 1'b0);
    sendKey(8'h2D, 1'b0);
    sendKey(8'h4B, 1'b0);
    pushExp(12'd70, 32'd1);
    wrReadyA = 1'b1;
    waitDrain(10);

    // Restart, then hand the move to black: white gets the increment
    pushExp(12'd67, 32'd1);
    sendKey(8'h2D, 1'b0);
    checkOutput("r_white_b", 64'(whiteB), START_B);
    checkOutput("r_black_b", 64'(blackB), START_B);
    checkOutput("r_game_over_b", 64'(gameOverB), 64'd0);
    checkOutput("r_b_wr_valid", 64'(wrValidB), 64'd1);
    checkOutput("r_b_wr_addr", 64'(wrAddrB), 64'd67);
    checkOutput("r_b_wr_data", 64'(wrDataB), 64'd1);
    memAddr = 12'd66;
    memData = 32'd1;
    stepCycle();
    memAddr = 12'd0;
    memData = 32'd0;
    checkOutput("incr_white", 64'(whiteB), 64'd13);
    checkOutput("incr_black_dec", 64'(blackB), 64'd9);
    for (int k = 1; k <= 9; k++) begin
      stepCycle();
      checkOutput("black_count", 64'(blackB), 64'(9 - k));
    end
    checkOutput("flag_game_over", 64'(gameOverB), 64'd1);
    checkOutput("flag_winner_white", 64'(winnerB), 64'd0);
    repeat (3) stepCycle();
    checkOutput("frozen_black", 64'(blackB), 64'd0);
    checkOutput("frozen_white", 64'(whiteB), 64'd13);
    checkOutput("frozen_game_over", 64'(gameOverB), 64'd1);

    // Restart from game over
    pushExp(12'd70, 32'd1);
    sendKey(8'h4B, 1'b0);
    checkOutput("l_game_over", 64'(gameOverB), 64'd0);
    checkOutput("l_white", 64'(whiteB), START_B);
    checkOutput("l_black", 64'(blackB), START_B);

    // Pause: same turn value, no increment, clocks frozen, moves dropped
    memAddr = 12'd66;
    memData = 32'd2;
    stepCycle();
    memAddr = 12'd0;
    memData = 32'd0;
    checkOutput("pause_white", 64'(whiteB), START_B);
    repeat (3) stepCycle();
    checkOutput("paused_white", 64'(whiteB), START_B);
    checkOutput("paused_black", 64'(blackB), START_B);
    sendKey(8'h6B, 1'b0);
    sendKey(8'h24, 1'b0);
    sendKey(8'h25, 1'b0);
    repeat (3) stepCycle();
    checkOutput("paused_no_write", 64'(wrValidA), 64'd0);
    pushExp(12'd67, 32'd1);
    sendKey(8'h2D, 1'b0);
    checkOutput("unpause_reload", 64'(whiteB), START_B);
    stepCycle();
    checkOutput("unpause_runs", 64'(whiteB), 64'd9);
    waitDrain(10);

    // Reset in the middle of a pending request
    wrReadyA = 1'b0;
    sendKey(8'h6B, 1'b0);
    sendKey(8'h24, 1'b0);
    sendKey(8'h25, 1'b0);
    checkOutput("pre_reset_valid", 64'(wrValidA), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async_reset_valid", 64'(wrValidA), 64'd0);
    checkOutput("async_reset_addr", 64'(wrAddrA), 64'd64);
    checkOutput("async_reset_white_b", 64'(whiteB), START_B);
    stepCycle();
    reset_n  = 1'b1;
    wrReadyA = 1'b1;
    repeat (3) stepCycle();
    checkOutput("post_reset_idle", 64'(wrValidA), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
